// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, 640x480@60 timing constants and counter types
package vga_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    localparam int H_ACTIVE = SCREEN_WIDTH;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = SCREEN_HEIGHT;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int HCOUNT_WIDTH = 10;
    localparam int VCOUNT_WIDTH = 10;

    typedef logic [HCOUNT_WIDTH-1:0] hcount_t;
    typedef logic [VCOUNT_WIDTH-1:0] vcount_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - raster position/sync bundle; src = timing generator, dst = renderers
interface vga_if;
    import vga_pkg::*;

    hcount_t hcount;
    vcount_t vcount;
    logic    hsync;
    logic    vsync;
    logic    blank;

    modport src (output hcount, vcount, hsync, vsync, blank);
    modport dst (input  hcount, vcount, hsync, vsync, blank);
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with registered sync/blank decode
// Ports: clk, rst_n (async active-low), step (advance), clear (sync return to 0),
//        count (registered position), wrap (comb: stepping past the last position),
//        sync/blank (registered, decoded from the same next-state value as count)
module vga_axis_counter #(
    parameter int   ACTIVE     = 640,
    parameter int   FP         = 16,
    parameter int   SYNC       = 96,
    parameter int   BP         = 48,
    parameter int   WIDTH      = 10,
    parameter logic SYNC_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             blank
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    logic [WIDTH-1:0] count_next;
    logic             at_last;

    assign at_last = (int'(count) == TOTAL - 1);
    assign wrap    = step && !clear && at_last;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (step) begin
            count_next = at_last ? '0 : count + 1'b1;
        end
    end

    // Decoding from count_next keeps sync/blank aligned with the count they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sync  <= ~SYNC_LEVEL;
            blank <= 1'b0;
        end else begin
            count <= count_next;
            sync  <= (int'(count_next) >= ACTIVE + FP && int'(count_next) < ACTIVE + FP + SYNC)
                     ? SYNC_LEVEL : ~SYNC_LEVEL;
            blank <= (int'(count_next) >= ACTIVE);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing source with line/frame start pulses
// Ports: clk_in, rst_n_in (async active-low), pix_en_in (pixel strobe),
//        vga_out (vga_if.src: hcount, vcount, hsync, vsync, blank),
//        line_start_out / frame_start_out (one-cycle wrap pulses),
//        frame_count_out[15:0] only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        pix_en_in,
    vga_if.src          vga_out,
    output logic        line_start_out,
`ifdef VGA_FRAME_COUNT_EN
    output logic        frame_start_out,
    output logic [15:0] frame_count_out
`else
    output logic        frame_start_out
`endif
);
    import vga_pkg::hcount_t;
    import vga_pkg::vcount_t;
    import vga_pkg::HCOUNT_WIDTH;
    import vga_pkg::VCOUNT_WIDTH;
    import vga_pkg::SYNC_ACTIVE;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOT > 2 ** HCOUNT_WIDTH) begin : g_h_too_wide
        $error("vga_timing_gen: horizontal total does not fit hcount");
    end
    if (V_TOT > 2 ** VCOUNT_WIDTH) begin : g_v_too_wide
        $error("vga_timing_gen: vertical total does not fit vcount");
    end

    hcount_t h_count;
    vcount_t v_count;
    logic    h_wrap, v_wrap;
    logic    h_sync, v_sync;
    logic    h_blank, v_blank;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .WIDTH(HCOUNT_WIDTH), .SYNC_LEVEL(SYNC_ACTIVE)
    ) u_h_axis (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .step  (pix_en_in),
        .clear (1'b0),
        .count (h_count),
        .wrap  (h_wrap),
        .sync  (h_sync),
        .blank (h_blank)
    );

    // The vertical axis advances in the same edge the horizontal one wraps,
    // so both counters always name the same pixel.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .WIDTH(VCOUNT_WIDTH), .SYNC_LEVEL(SYNC_ACTIVE)
    ) u_v_axis (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .step  (h_wrap & pix_en_in),
        .clear (1'b0),
        .count (v_count),
        .wrap  (v_wrap),
        .sync  (v_sync),
        .blank (v_blank)
    );

    assign vga_out.hcount = h_count;
    assign vga_out.vcount = v_count;
    assign vga_out.hsync  = h_sync;
    assign vga_out.vsync  = v_sync;
    assign vga_out.blank  = h_blank | v_blank;

    // Pulses follow the wrap that just moved the counters; a disabled cycle
    // has no wrap, so a pulse never stretches across held cycles.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            line_start_out  <= h_wrap;
            frame_start_out <= v_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_count_out <= 16'd0;
        end else if (v_wrap) begin
            frame_count_out <= frame_count_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen (full-size and reduced-geometry instances)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;
    logic ls_big, fs_big, ls_sm, fs_sm;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_big_o, fc_sm_o;
`endif

    always #5 clk = ~clk;

    vga_if vif_big ();
    vga_if vif_sm ();

    vga_timing_gen dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .pix_en_in       (pix_en),
        .vga_out         (vif_big),
        .line_start_out  (ls_big),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count_out (fc_big_o),
`endif
        .frame_start_out (fs_big)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_sm (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .pix_en_in       (pix_en),
        .vga_out         (vif_sm),
        .line_start_out  (ls_sm),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count_out (fc_sm_o),
`endif
        .frame_start_out (fs_sm)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a pixel index within the frame; h/v/sync/blank follow arithmetically.
    int p_big = 0, p_sm = 0;
    bit e_ls_big, e_fs_big, e_ls_sm, e_fs_sm;
    int fc_big = 0, fc_sm = 0;

    task automatic chk(input string nm, input int p, input int ha, input int hf, input int hs,
                       input int ht, input int va, input int vf, input int vs,
                       input bit els, input bit efs,
                       input logic [9:0] ah, input logic [9:0] av, input logic ahs,
                       input logic avs, input logic abl, input logic als, input logic afs);
        int   eh, ev;
        logic ehs, evs, ebl;
        eh  = p % ht;
        ev  = p / ht;
        ehs = (eh >= ha + hf && eh < ha + hf + hs) ? 1'b0 : 1'b1;
        evs = (ev >= va + vf && ev < va + vf + vs) ? 1'b0 : 1'b1;
        ebl = (eh >= ha) || (ev >= va);
        n_vec++;
        if (ah !== 10'(eh) || av !== 10'(ev) || ahs !== ehs || avs !== evs ||
            abl !== ebl || als !== els || afs !== efs) begin
            n_err++;
            $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                     nm, $time, ah, av, ahs, avs, abl, als, afs, eh, ev, ehs, evs, ebl, els, efs);
        end
    endtask

    task automatic expect_int(input string nm, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic check_both();
        chk("big", p_big, 640, 16, 96, 800, 480, 10, 2, e_ls_big, e_fs_big,
            vif_big.hcount, vif_big.vcount, vif_big.hsync, vif_big.vsync, vif_big.blank, ls_big, fs_big);
        chk("small", p_sm, 16, 2, 3, 23, 12, 2, 2, e_ls_sm, e_fs_sm,
            vif_sm.hcount, vif_sm.vcount, vif_sm.hsync, vif_sm.vsync, vif_sm.blank, ls_sm, fs_sm);
`ifdef VGA_FRAME_COUNT_EN
        expect_int("frame_count_big", int'(fc_big_o), fc_big);
        expect_int("frame_count_small", int'(fc_sm_o), fc_sm);
`endif
    endtask

    function automatic void model_reset();
        p_big = 0; p_sm = 0;
        e_ls_big = 0; e_fs_big = 0; e_ls_sm = 0; e_fs_sm = 0;
        fc_big = 0; fc_sm = 0;
    endfunction

    // Called at a falling edge: drive, take one rising edge, update model, check.
    task automatic step(input bit en);
        pix_en = en;
        @(posedge clk);
        if (rst_n && en) begin
            p_big = (p_big + 1) % (800 * 525);
            p_sm  = (p_sm + 1) % (23 * 19);
            e_ls_big = (p_big % 800 == 0);
            e_fs_big = (p_big == 0);
            e_ls_sm  = (p_sm % 23 == 0);
            e_fs_sm  = (p_sm == 0);
            if (e_fs_big) fc_big = (fc_big + 1) % 65536;
            if (e_fs_sm)  fc_sm  = (fc_sm + 1) % 65536;
        end else begin
            e_ls_big = 0; e_fs_big = 0; e_ls_sm = 0; e_fs_sm = 0;
        end
        @(negedge clk);
        check_both();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pix_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_both();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit en;
        int h;
        int v;
        bit hs;
        bit bl;
        bit ls;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n_ls, n_low, first_low, first_blank, hold_bad, dbl, prev_ls, n_fs, n_vlow, bl_bad, hh;

        tbl[0] = '{0, 0, 0, 1, 0, 0};
        tbl[1] = '{1, 1, 0, 1, 0, 0};
        tbl[2] = '{0, 1, 0, 1, 0, 0};
        tbl[3] = '{1, 2, 0, 1, 0, 0};
        tbl[4] = '{1, 3, 0, 1, 0, 0};
        tbl[5] = '{0, 3, 0, 1, 0, 0};
        tbl[6] = '{1, 4, 0, 1, 0, 0};
        tbl[7] = '{1, 5, 0, 1, 0, 0};

        // Reset state
        @(negedge clk);
        do_reset();
        expect_int("reset_hsync", int'(vif_big.hsync), 1);
        expect_int("reset_vsync", int'(vif_big.vsync), 1);
        expect_int("reset_blank", int'(vif_big.blank), 0);

        // Table vectors right after release
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].en);
            expect_int($sformatf("tbl%0d_h", i), int'(vif_big.hcount), tbl[i].h);
            expect_int($sformatf("tbl%0d_v", i), int'(vif_big.vcount), tbl[i].v);
            expect_int($sformatf("tbl%0d_hs", i), int'(vif_big.hsync), int'(tbl[i].hs));
            expect_int($sformatf("tbl%0d_bl", i), int'(vif_big.blank), int'(tbl[i].bl));
            expect_int($sformatf("tbl%0d_ls", i), int'(ls_big), int'(tbl[i].ls));
        end

        // One full line at clock rate
        do_reset();
        n_ls = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            if (ls_big) n_ls++;
        end
        expect_int("line0_ls_count", n_ls, 1);
        expect_int("line0_end_h", int'(vif_big.hcount), 0);
        expect_int("line0_end_v", int'(vif_big.vcount), 1);

        // Second line: hsync width/position and blank edges
        n_low = 0; first_low = -1; first_blank = -1;
        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            if (!vif_big.hsync) begin
                n_low++;
                if (first_low < 0) first_low = int'(vif_big.hcount);
            end
            if (vif_big.blank && first_blank < 0) first_blank = int'(vif_big.hcount);
        end
        expect_int("hsync_low_cycles", n_low, 96);
        expect_int("hsync_first_h", first_low, 656);
        expect_int("blank_rise_h", first_blank, 640);
        expect_int("blank_after_wrap", int'(vif_big.blank), 0);

        // Half-rate pixel strobe
        hold_bad = 0; dbl = 0; prev_ls = 0;
        for (int i = 0; i < 820; i++) begin
            step(1'b1);
            hh = int'(vif_big.hcount);
            if (prev_ls && ls_big) dbl++;
            prev_ls = int'(ls_big);
            step(1'b0);
            if (int'(vif_big.hcount) != hh) hold_bad++;
            if (prev_ls && ls_big) dbl++;
            prev_ls = int'(ls_big);
        end
        expect_int("half_rate_hold_violations", hold_bad, 0);
        expect_int("half_rate_double_pulses", dbl, 0);

        // Two full frames on the reduced-geometry instance
        do_reset();
        n_fs = 0; n_vlow = 0; bl_bad = 0;
        for (int i = 0; i < 2 * 437; i++) begin
            step(1'b1);
            if (fs_sm) begin
                n_fs++;
                expect_int("frame_start_at_h", int'(vif_sm.hcount), 0);
                expect_int("frame_start_at_v", int'(vif_sm.vcount), 0);
            end
            if (!vif_sm.vsync) n_vlow++;
            if (vif_sm.vcount >= 10'd12 && !vif_sm.blank) bl_bad++;
        end
        expect_int("small_frame_starts", n_fs, 2);
        expect_int("small_vsync_low_cycles", n_vlow, 2 * 2 * 23);
        expect_int("small_blank_violations", bl_bad, 0);

        // Random pixel strobe against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0);
        end

        // Asynchronous reset mid-line, between clock edges
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1);
        expect_int("pre_async_h", int'(vif_big.hcount), 300);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_both();
        expect_int("async_h", int'(vif_big.hcount), 0);
        expect_int("async_fs", int'(fs_big), 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_n = 1'b1;
        step(1'b1);
        expect_int("post_release_h", int'(vif_big.hcount), 1);
        expect_int("post_release_fs", int'(fs_big), 0);
        for (int i = 0; i < 40; i++) step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
